fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
Forwarding and hazard control for the 5-stage pipeline. Tracks the destination registers of in-flight instructions in EX, MEM and WB in internal shadow registers. Produces the registered Forward1A/Forward1B selects that steer the EX-stage forwarding muxes, plus the load-use and multiply/divide-busy stall controls. Sits beside the ID/EX pipeline register and updates on the same edge.

Parameters:
- RA_W, 5, register address width.
- MD_LATENCY, 32, cycles the mult/div unit is busy after a start; must be ≥1.
- MD_CNT_W, 6, width of the busy counter; must satisfy 2^MD_CNT_W > MD_LATENCY.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RA_W  ID source register 1.
- id_rt  in  RA_W  ID source register 2.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_dst  in  RA_W  ID destination register (already muxed rd/rt/31).
- id_reg_write  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a load (result available after MEM).
- id_md_use  in  1  instruction starts mult/div or reads HI/LO.
- id_md_start  in  1  instruction starts mult/div (implies id_md_use).
- ex_flush  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- Forward1A  out  2  registered EX select for operand A: 10 = EX/MEM result, 01 = MEM/WB result, 00 = register file.
- Forward1B  out  2  same encoding for operand B.
- stall  out  1  hold PC and IF/ID, and insert a bubble into ID/EX.
- md_busy  out  1  busy counter is non-zero.

Behaviour:
- Shadow stages ex_*, mem_*, wb_*: each holds {dst, reg_write, is_load}. Reset clears all three. A bubble is reg_write=0, is_load=0.
- Every edge: wb <= mem and mem <= ex.
  - ex <= ID info when id_valid && !stall && !ex_flush.
  - Otherwise ex <= bubble.
- A stage matches a source register when reg_write=1, dst≠0, dst equals the source, and the use_* bit is 1. Register 0 never forwards and never stalls.
- Select next value, computed from ID vs the shadows before the edge:
  - ex-stage match → 10 (the producer sits in EX/MEM when the consumer reaches EX).
  - else mem-stage match → 01.
  - else 00.
  - When the ex match and the mem match hit the same register, the ex match wins (newest value).
- Forward1A/Forward1B register the next value on edges where the instruction enters EX. They register 00 on bubble edges (stall, flush, !id_valid).
- wb-stage producers are not forwarded. The register file is write-before-read, so they select 00.
- Load-use: stall=1 when ex.is_load and ex matches rs or rt.
  - Exactly one cycle, because the load then moves to MEM.
  - The re-evaluated select then becomes 01.
- MD: the counter loads MD_LATENCY on an accepted id_md_start and decrements to 0 each cycle.
  - md_busy = (cnt≠0).
  - stall=1 when id_valid && id_md_use && md_busy, including a second id_md_start.
- stall = id_valid && !ex_flush && (load_use || md_hazard). stall is combinational from the current state and inputs.
- ex_flush overrides: stall=0, the ID instruction is discarded, and id_md_start is ignored.
- Stall and flush in the same cycle: flush wins.
- The counter is unaffected by stall/flush except that starts occur only when accepted.
- Reset, including mid-stall or mid-MD: Forward1A=Forward1B=00, stall=0, md_busy=0, counter=0, shadows cleared. There is no residual hazard after reset deasserts.
- Latency: select registered 1 cycle after ID evaluation; stall same-cycle.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 back-to-back → at sub's EX cycle Forward1A=10, Forward1B=00, stall never 1.
- add $3 ; nop ; or $6,$7,$3 → at or's EX cycle Forward1B=01; with two nops → Forward1B=00.
- lw $8,0($1) then add $9,$8,$8 → stall=1 for exactly one cycle, one bubble in EX (Forward=00), then add's EX cycle Forward1A=Forward1B=01.
- Writes to $0 followed by readers of $0 → Forward=00 and no stall, even when the producer is a load. Two producers of $5 (EX and MEM) → select 10.
- MD_LATENCY=4: mult at cycle 0, mfhi at cycle 1 → md_busy cycles 1–4, stall cycles 1–4, mfhi enters EX at cycle 5. Assert ex_flush during a load-use stall → stall drops the same cycle and the ID instruction never reaches the shadows.
- Assert rst mid-MD (counter=2) and mid-stall → all outputs 0 immediately (asynchronous). After release, an independent instruction sees no stall.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and stall control for the 5-stage pipeline.
// Shadows of the EX/MEM destinations plus a mult/div busy down-counter.
module fwd_hazard_ctrl #(
   parameter int RA_W       = 5,
   parameter int MD_LATENCY = 32,
   parameter int MD_CNT_W   = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic [RA_W-1:0] id_dst,
   input  logic            id_reg_write,
   input  logic            id_is_load,
   input  logic            id_md_use,
   input  logic            id_md_start,
   input  logic            ex_flush,
   output logic [1:0]      Forward1A,
   output logic [1:0]      Forward1B,
   output logic            stall,
   output logic            md_busy
);

   // The WB shadow is not kept: the register file is write-before-read, so a
   // WB producer always resolves to the register-file path (select 00).
   logic [RA_W-1:0]     ex_dst_q, ex_dst_d;
   logic                ex_rw_q, ex_rw_d;
   logic                ex_ld_q, ex_ld_d;
   logic [RA_W-1:0]     mem_dst_q;
   logic                mem_rw_q;
   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [1:0]          fwd_a_q, fwd_a_d;
   logic [1:0]          fwd_b_q, fwd_b_d;

   logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
   logic load_use, md_hazard, accept;

   assign ex_hit_rs  = id_use_rs && ex_rw_q  && (ex_dst_q  != '0) && (ex_dst_q  == id_rs);
   assign ex_hit_rt  = id_use_rt && ex_rw_q  && (ex_dst_q  != '0) && (ex_dst_q  == id_rt);
   assign mem_hit_rs = id_use_rs && mem_rw_q && (mem_dst_q != '0) && (mem_dst_q == id_rs);
   assign mem_hit_rt = id_use_rt && mem_rw_q && (mem_dst_q != '0) && (mem_dst_q == id_rt);

   assign md_busy   = (md_cnt_q != '0);
   assign load_use  = ex_ld_q && (ex_hit_rs || ex_hit_rt);
   assign md_hazard = id_md_use && md_busy;
   assign stall     = id_valid && !ex_flush && (load_use || md_hazard);
   assign accept    = id_valid && !ex_flush && !stall;

   always_comb begin
      ex_dst_d = '0;
      ex_rw_d  = 1'b0;
      ex_ld_d  = 1'b0;
      fwd_a_d  = 2'b00;
      fwd_b_d  = 2'b00;
      md_cnt_d = md_cnt_q;
      if (md_busy) begin
         md_cnt_d = md_cnt_q - MD_CNT_W'(1);
      end
      if (accept) begin
         ex_dst_d = id_dst;
         ex_rw_d  = id_reg_write;
         ex_ld_d  = id_is_load;
         // Newest producer wins when both stages hold the same register.
         if (ex_hit_rs)       fwd_a_d = 2'b10;
         else if (mem_hit_rs) fwd_a_d = 2'b01;
         if (ex_hit_rt)       fwd_b_d = 2'b10;
         else if (mem_hit_rt) fwd_b_d = 2'b01;
         if (id_md_start) begin
            md_cnt_d = MD_CNT_W'(MD_LATENCY);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_dst_q  <= '0;
         ex_rw_q   <= 1'b0;
         ex_ld_q   <= 1'b0;
         mem_dst_q <= '0;
         mem_rw_q  <= 1'b0;
         md_cnt_q  <= '0;
         fwd_a_q   <= 2'b00;
         fwd_b_q   <= 2'b00;
      end else begin
         mem_dst_q <= ex_dst_q;
         mem_rw_q  <= ex_rw_q;
         ex_dst_q  <= ex_dst_d;
         ex_rw_q   <= ex_rw_d;
         ex_ld_q   <= ex_ld_d;
         md_cnt_q  <= md_cnt_d;
         fwd_a_q   <= fwd_a_d;
         fwd_b_q   <= fwd_b_d;
      end
   end

   assign Forward1A = fwd_a_q;
   assign Forward1B = fwd_b_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios plus
// random traffic against a per-cycle issue-history reference model.
module tb_fwd_hazard_ctrl;
   localparam int RA_W     = 5;
   localparam int MD_LAT   = 4;
   localparam int MD_CNT_W = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
   logic            id_md_use, id_md_start, ex_flush;
   logic [RA_W-1:0] id_rs, id_rt, id_dst;
   logic [1:0]      Forward1A, Forward1B;
   logic            stall, md_busy;

   fwd_hazard_ctrl #(.RA_W(RA_W), .MD_LATENCY(MD_LAT), .MD_CNT_W(MD_CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_md_use(id_md_use),
      .id_md_start(id_md_start), .ex_flush(ex_flush), .Forward1A(Forward1A),
      .Forward1B(Forward1B), .stall(stall), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [4:0] rs, rt, dst;
      logic       use_rs, use_rt, rw, ld, md_use, md_start, flush;
   } instr_t;

   // One entry per cycle: what entered EX on that edge (a bubble if nothing).
   typedef struct {
      logic       rw, ld;
      logic [4:0] dst;
   } rec_t;

   rec_t hist0, hist1;
   int   cyc, md_start_cyc;
   int   total, bad;
   logic obs_stall, obs_busy, m_stall, m_busy;
   logic [1:0] obs_fa, obs_fb, m_fa, m_fb;

   function automatic logic reads(rec_t r, logic [4:0] src, logic u);
      return u && r.rw && (r.dst != 5'd0) && (r.dst == src);
   endfunction

   function automatic instr_t mk(logic [4:0] dst, logic [4:0] rs, logic [4:0] rt,
                                 logic use_rs, logic use_rt, logic rw, logic ld);
      instr_t i;
      i.valid = 1'b1; i.dst = dst; i.rs = rs; i.rt = rt;
      i.use_rs = use_rs; i.use_rt = use_rt; i.rw = rw; i.ld = ld;
      i.md_use = 1'b0; i.md_start = 1'b0; i.flush = 1'b0;
      return i;
   endfunction

   function automatic instr_t nop();
      return mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic model_reset();
      hist0 = '{1'b0, 1'b0, 5'd0};
      hist1 = '{1'b0, 1'b0, 5'd0};
      md_start_cyc = -1000;
   endtask

   task automatic apply(input instr_t i);
      id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_dst = i.dst;
      id_use_rs = i.use_rs; id_use_rt = i.use_rt; id_reg_write = i.rw;
      id_is_load = i.ld; id_md_use = i.md_use; id_md_start = i.md_start;
      ex_flush = i.flush;
   endtask

   // Present one ID instruction for one cycle; records observed and model values.
   task automatic drive(input instr_t i);
      rec_t nr;
      logic acc;
      apply(i);
      #1;
      m_busy  = (cyc - md_start_cyc >= 1) && (cyc - md_start_cyc <= MD_LAT);
      m_stall = i.valid && !i.flush &&
                ((hist0.ld && (reads(hist0, i.rs, i.use_rs) || reads(hist0, i.rt, i.use_rt)))
                 || (i.md_use && m_busy));
      acc  = i.valid && !i.flush && !m_stall;
      m_fa = !acc ? 2'd0 : reads(hist0, i.rs, i.use_rs) ? 2'd2 :
             reads(hist1, i.rs, i.use_rs) ? 2'd1 : 2'd0;
      m_fb = !acc ? 2'd0 : reads(hist0, i.rt, i.use_rt) ? 2'd2 :
             reads(hist1, i.rt, i.use_rt) ? 2'd1 : 2'd0;
      obs_stall = stall;
      obs_busy  = md_busy;
      @(posedge clk);
      #1;
      obs_fa = Forward1A;
      obs_fb = Forward1B;
      nr.rw  = acc & i.rw;
      nr.ld  = acc & i.ld;
      nr.dst = acc ? i.dst : 5'd0;
      hist1 = hist0;
      hist0 = nr;
      if (acc && i.md_start) md_start_cyc = cyc;
      cyc++;
   endtask

   task automatic test_reset();
      total++; if (Forward1A !== 2'b00) begin bad++; $display("FAIL reset_fa got=%b want=00", Forward1A); end
      total++; if (Forward1B !== 2'b00) begin bad++; $display("FAIL reset_fb got=%b want=00", Forward1B); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
      total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", md_busy); end
   endtask

   task automatic test_raw_ex();
      drive(nop()); drive(nop());
      drive(mk(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL raw_ex_stall_add got=%b want=0", obs_stall); end
      drive(mk(5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL raw_ex_stall_sub got=%b want=0", obs_stall); end
      total++; if (obs_fa !== 2'b10) begin bad++; $display("FAIL raw_ex_fa got=%b want=10", obs_fa); end
      total++; if (obs_fb !== 2'b00) begin bad++; $display("FAIL raw_ex_fb got=%b want=00", obs_fb); end
   endtask

   task automatic test_raw_mem();
      drive(nop()); drive(nop());
      drive(mk(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
      drive(nop());
      drive(mk(5'd6, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_fb !== 2'b01) begin bad++; $display("FAIL raw_mem_fb got=%b want=01", obs_fb); end
      drive(mk(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
      drive(nop()); drive(nop());
      drive(mk(5'd6, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_fb !== 2'b00) begin bad++; $display("FAIL raw_wb_fb got=%b want=00", obs_fb); end
   endtask

   task automatic test_load_use();
      instr_t a;
      drive(nop()); drive(nop());
      drive(mk(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
      a = mk(5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(a);
      total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%b want=1", obs_stall); end
      total++; if (obs_fa !== 2'b00) begin bad++; $display("FAIL lu_bubble_fa got=%b want=00", obs_fa); end
      drive(a);
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%b want=0", obs_stall); end
      total++; if (obs_fa !== 2'b01) begin bad++; $display("FAIL lu_fa got=%b want=01", obs_fa); end
      total++; if (obs_fb !== 2'b01) begin bad++; $display("FAIL lu_fb got=%b want=01", obs_fb); end
   endtask

   task automatic test_zero_and_double();
      drive(nop()); drive(nop());
      drive(mk(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
      drive(mk(5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b want=0", obs_stall); end
      total++; if (obs_fa !== 2'b00) begin bad++; $display("FAIL zero_fa got=%b want=00", obs_fa); end
      drive(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
      drive(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
      drive(mk(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_fa !== 2'b10) begin bad++; $display("FAIL double_fa got=%b want=10", obs_fa); end
      total++; if (obs_fb !== 2'b10) begin bad++; $display("FAIL double_fb got=%b want=10", obs_fb); end
   endtask

   task automatic test_md();
      instr_t m, f;
      int n, stalls, busys;
      drive(nop()); drive(nop());
      m = nop(); m.md_use = 1'b1; m.md_start = 1'b1;
      drive(m);
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL md_start_stall got=%b want=0", obs_stall); end
      f = mk(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); f.md_use = 1'b1;
      n = 0; stalls = 0; busys = 0;
      do begin
         drive(f);
         if (obs_stall) stalls++;
         if (obs_busy) busys++;
         n++;
      end while (obs_stall && n < 20);
      total++; if (n >= 20) begin bad++; $display("FAIL md_timeout cycles=%0d limit=20", n); end
      total++; if (stalls != MD_LAT) begin bad++; $display("FAIL md_stalls got=%0d want=%0d", stalls, MD_LAT); end
      total++; if (busys != MD_LAT) begin bad++; $display("FAIL md_busy_cycles got=%0d want=%0d", busys, MD_LAT); end
   endtask

   task automatic test_flush();
      instr_t a;
      drive(nop()); drive(nop());
      drive(mk(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
      a = mk(5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0); a.flush = 1'b1;
      drive(a);
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", obs_stall); end
      total++; if (obs_fa !== 2'b00) begin bad++; $display("FAIL flush_fa got=%b want=00", obs_fa); end
      drive(mk(5'd11, 5'd9, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_fa !== 2'b00) begin bad++; $display("FAIL flush_leak_fa got=%b want=00", obs_fa); end
      total++; if (obs_fb !== 2'b01) begin bad++; $display("FAIL flush_lw_fb got=%b want=01", obs_fb); end
   endtask

   task automatic test_reset_mid();
      instr_t m;
      drive(nop()); drive(nop());
      m = nop(); m.md_use = 1'b1; m.md_start = 1'b1;
      drive(m);
      drive(mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0));
      drive(mk(5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
      total++; if (obs_fa !== 2'b10) begin bad++; $display("FAIL pre_rst_fa got=%b want=10", obs_fa); end
      apply(mk(5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
      #1;
      total++; if (stall !== 1'b1 || md_busy !== 1'b1) begin
         bad++; $display("FAIL pre_rst_hazard stall=%b busy=%b want=1/1", stall, md_busy); end
      rst = 1'b1;
      #1;
      total++; if (stall !== 1'b0 || md_busy !== 1'b0 || Forward1A !== 2'b00 || Forward1B !== 2'b00) begin
         bad++; $display("FAIL async_rst stall=%b busy=%b fa=%b fb=%b want=0/0/00/00",
                         stall, md_busy, Forward1A, Forward1B); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(mk(5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0));
      total++; if (obs_stall !== 1'b0 || obs_busy !== 1'b0) begin
         bad++; $display("FAIL post_rst stall=%b busy=%b want=0/0", obs_stall, obs_busy); end
      total++; if (obs_fa !== 2'b00) begin bad++; $display("FAIL post_rst_fa got=%b want=00", obs_fa); end
   endtask

   task automatic test_random();
      instr_t i;
      for (int k = 0; k < 400; k++) begin
         i.valid    = ($urandom_range(0, 9) != 0);
         i.rs       = 5'($urandom_range(0, 3));
         i.rt       = 5'($urandom_range(0, 3));
         i.dst      = 5'($urandom_range(0, 3));
         i.use_rs   = 1'($urandom_range(0, 1));
         i.use_rt   = 1'($urandom_range(0, 1));
         i.rw       = ($urandom_range(0, 3) != 0);
         i.ld       = ($urandom_range(0, 2) == 0);
         i.md_start = ($urandom_range(0, 11) == 0);
         i.md_use   = i.md_start | ($urandom_range(0, 5) == 0);
         i.flush    = ($urandom_range(0, 9) == 0);
         drive(i);
         total++; if (obs_stall !== m_stall) begin bad++; $display("FAIL rnd_stall k=%0d got=%b want=%b", k, obs_stall, m_stall); end
         total++; if (obs_busy !== m_busy) begin bad++; $display("FAIL rnd_busy k=%0d got=%b want=%b", k, obs_busy, m_busy); end
         total++; if (obs_fa !== m_fa) begin bad++; $display("FAIL rnd_fa k=%0d got=%b want=%b", k, obs_fa, m_fa); end
         total++; if (obs_fb !== m_fb) begin bad++; $display("FAIL rnd_fb k=%0d got=%b want=%b", k, obs_fb, m_fb); end
      end
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      model_reset();
      rst = 1'b1;
      apply(nop());
      id_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      test_raw_ex();
      test_raw_mem();
      test_load_use();
      test_zero_and_double();
      test_md();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
